// File: rtl/if_id_queue.sv
// Instruction buffer between fetch and decode: DEPTH-entry FIFO of {pc, inst}
// with valid/ready on both sides and a synchronous flush for redirects.
module if_id_queue #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned INST_W = 32,
   parameter int unsigned DEPTH  = 4,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              if_valid_i,
   output logic              if_ready_o,
   input  logic [ADDR_W-1:0] if_pc_i,
   input  logic [INST_W-1:0] if_inst_i,
   output logic              id_valid_o,
   input  logic              id_ready_i,
   output logic [ADDR_W-1:0] id_pc_o,
   output logic [INST_W-1:0] id_inst_o,
   output logic [CNT_W-1:0]  count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [ADDR_W-1:0] pc_q   [DEPTH];
   logic [INST_W-1:0] inst_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push, pop;

   // Full refuses pushes even when a pop happens in the same cycle.
   assign if_ready_o = (cnt_q != CNT_W'(DEPTH));
   assign id_valid_o = (cnt_q != '0);
   assign count_o    = cnt_q;

   assign push = if_valid_i && if_ready_o;
   assign pop  = id_valid_o && id_ready_i;

   // Empty queue presents an all-zero bubble; storage itself is never cleared.
   assign id_pc_o   = id_valid_o ? pc_q[rd_ptr_q]   : '0;
   assign id_inst_o = id_valid_o ? inst_q[rd_ptr_q] : '0;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && !flush_i && push) begin
         pc_q[wr_ptr_q]   <= if_pc_i;
         inst_q[wr_ptr_q] <= if_inst_i;
      end
   end

endmodule
